// File: rtl/cpu4_pkg.sv
// cpu4_pkg: shared definitions for the 4-bit CPU execute stage.
//   - CPU4_WIDTH      : default data/address width
//   - SX_* / SY_*     : operand-X / operand-Y select encodings
//   - state_t         : RUN/HALT state of the execute stage
package cpu4_pkg;

  localparam int CPU4_WIDTH = 4;

  // Operand-X select (s0)
  localparam logic [1:0] SX_A    = 2'b00;
  localparam logic [1:0] SX_B    = 2'b01;
  localparam logic [1:0] SX_IN   = 2'b10;
  localparam logic [1:0] SX_ZERO = 2'b11;

  // Operand-Y select (s1)
  localparam logic [1:0] SY_ZERO = 2'b00;
  localparam logic [1:0] SY_IM   = 2'b01;
  localparam logic [1:0] SY_A    = 2'b10;
  localparam logic [1:0] SY_B    = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/cpu4_alu.sv
// cpu4_alu: combinational operand muxes and adder for the execute stage.
// Ports:
//   s0, s1   : operand-X / operand-Y selects
//   im       : immediate operand
//   a, b     : A and B register values
//   in_port  : external input switches
//   sum      : X + Y modulo 2^WIDTH (carry-out dropped)
//   zero     : sum == 0
module cpu4_alu
  import cpu4_pkg::*;
#(
  parameter int WIDTH = CPU4_WIDTH
) (
  input  logic [1:0]       s0,
  input  logic [1:0]       s1,
  input  logic [WIDTH-1:0] im,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sum,
  output logic             zero
);

  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;

  // Operand-X multiplexer
  always_comb begin
    x_s = {WIDTH{1'b0}};
    case (s0)
      SX_A:    x_s = a;
      SX_B:    x_s = b;
      SX_IN:   x_s = in_port;
      SX_ZERO: x_s = {WIDTH{1'b0}};
      default: x_s = {WIDTH{1'b0}};
    endcase
  end

  // Operand-Y multiplexer
  always_comb begin
    y_s = {WIDTH{1'b0}};
    case (s1)
      SY_ZERO: y_s = {WIDTH{1'b0}};
      SY_IM:   y_s = im;
      SY_A:    y_s = a;
      SY_B:    y_s = b;
      default: y_s = {WIDTH{1'b0}};
    endcase
  end

  // Adder: the result is truncated to WIDTH bits, so the carry-out is lost
  always_comb begin
    sum  = x_s + y_s;
    zero = (sum == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/cpu4_datapath.sv
// cpu4_datapath: execute stage of the 4-bit CPU.
// Holds A, B, OUT, PC, the zero flag and the RUN/HALT state.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   en            : step enable; state only changes when en=1
//   im, s0, s1    : immediate and operand selects from the decoder
//   l0..l3        : load strobes for A, B, OUT, PC
//   hlt           : halt request (sticky until rst)
//   in_port       : external input switches
//   pc            : ROM address
//   out_port      : OUT register
//   reg_a, reg_b  : A and B registers (visibility)
//   zf            : registered zero flag back to the decoder
//   halted        : 1 while in HALT
module cpu4_datapath
  import cpu4_pkg::*;
#(
  parameter int                WIDTH    = CPU4_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] im,
  input  logic [1:0]       s0,
  input  logic [1:0]       s1,
  input  logic             l0,
  input  logic             l1,
  input  logic             l2,
  input  logic             l3,
  input  logic             hlt,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic             zf,
  output logic             halted
);

  localparam logic [WIDTH-1:0] PC_INC = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic             step_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] pc_r;
  logic             zf_r;
  logic [WIDTH-1:0] sum_s;
  logic             zero_s;

  cpu4_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .s0      (s0),
    .s1      (s1),
    .im      (im),
    .a       (a_r),
    .b       (b_r),
    .in_port (in_port),
    .sum     (sum_s),
    .zero    (zero_s)
  );

  // An instruction executes only when enabled, running, and not halting
  always_comb begin
    step_s = 1'b0;
    if (en && (state_r == RUN) && !hlt) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
  end

  // Halt FSM next-state: HALT is only left through reset
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (en && hlt) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = RUN;
    endcase
  end

  // Halt FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Architectural registers; the halting edge itself updates nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      out_r <= {WIDTH{1'b0}};
      pc_r  <= RESET_PC;
      zf_r  <= 1'b0;
    end else if (step_s) begin
      if (l0) a_r   <= sum_s;
      if (l1) b_r   <= sum_s;
      if (l2) out_r <= sum_s;
      // A jump takes priority over the sequential increment (and its wrap)
      if (l3) begin
        pc_r <= sum_s;
      end else begin
        pc_r <= pc_r + PC_INC;
      end
      zf_r <= zero_s;
    end
  end

  assign reg_a    = a_r;
  assign reg_b    = b_r;
  assign out_port = out_r;
  assign pc       = pc_r;
  assign zf       = zf_r;
  assign halted   = (state_r == HALT);

endmodule

// File: tb/tb_cpu4_datapath.sv
// tb_cpu4_datapath: directed self-checking bench for cpu4_datapath.
module tb_cpu4_datapath;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] im;
  logic [1:0] s0;
  logic [1:0] s1;
  logic       l0, l1, l2, l3;
  logic       hlt;
  logic [3:0] in_port;
  logic [3:0] pc;
  logic [3:0] out_port;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       zf;
  logic       halted;

  int tests;
  int fails;

  cpu4_datapath #(
    .WIDTH    (4),
    .RESET_PC (4'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .im       (im),
    .s0       (s0),
    .s1       (s1),
    .l0       (l0),
    .l1       (l1),
    .l2       (l2),
    .l3       (l3),
    .hlt      (hlt),
    .in_port  (in_port),
    .pc       (pc),
    .out_port (out_port),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .zf       (zf),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] x, input logic [1:0] y, input logic [3:0] imm,
                       input logic [3:0] strobes);
    s0 = x; s1 = y; im = imm;
    {l3, l2, l1, l0} = strobes;
  endtask

  task automatic check_all(input string tag, input logic [3:0] epc, input logic [3:0] ea,
                           input logic [3:0] eb, input logic [3:0] eout,
                           input logic ezf, input logic ehalt);
    check({tag, ".pc"},     {4'h0, pc},       {4'h0, epc});
    check({tag, ".a"},      {4'h0, reg_a},    {4'h0, ea});
    check({tag, ".b"},      {4'h0, reg_b},    {4'h0, eb});
    check({tag, ".out"},    {4'h0, out_port}, {4'h0, eout});
    check({tag, ".zf"},     {7'h0, zf},       {7'h0, ezf});
    check({tag, ".halted"}, {7'h0, halted},   {7'h0, ehalt});
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; en = 1'b0; hlt = 1'b0; in_port = 4'h0;
    drive(2'b11, 2'b00, 4'h0, 4'b0000);
    step(); step();
    rst = 1'b0;
    check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Plain steps: X=0, Y=0, no strobes
    en = 1'b1;
    step(); check_all("plain1", 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    step(); check("plain2.pc", {4'h0, pc}, 8'h02);
    step(); check_all("plain3", 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // Loads: A=0+5, B=A+3, OUT=B+0
    drive(2'b11, 2'b01, 4'h5, 4'b0001); step();
    check_all("lda", 4'h4, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(2'b00, 2'b01, 4'h3, 4'b0010); step();
    check_all("ldb", 4'h5, 4'h5, 4'h8, 4'h0, 1'b0, 1'b0);
    drive(2'b01, 2'b00, 4'h0, 4'b0100); step();
    check_all("ldout", 4'h6, 4'h5, 4'h8, 4'h8, 1'b0, 1'b0);

    // in_port + B = 6 + 8 = E into A
    in_port = 4'h6;
    drive(2'b10, 2'b11, 4'h0, 4'b0001); step();
    check_all("inport", 4'h7, 4'hE, 4'h8, 4'h8, 1'b0, 1'b0);
    // A + A = 0x1C truncated to C into B (carry dropped)
    drive(2'b00, 2'b10, 4'h0, 4'b0010); step();
    check_all("aplusa", 4'h8, 4'hE, 4'hC, 4'h8, 1'b0, 1'b0);

    // Data wrap: A=F, then A+1 -> 0 with zf=1
    drive(2'b11, 2'b01, 4'hF, 4'b0001); step();
    check("setf.a", {4'h0, reg_a}, 8'h0F);
    drive(2'b00, 2'b01, 4'h1, 4'b0001); step();
    check_all("awrap", 4'hA, 4'h0, 4'hC, 4'h8, 1'b1, 1'b0);

    // Jump to F, then PC wraps through 0 on plain steps
    drive(2'b11, 2'b01, 4'hF, 4'b1000); step();
    check_all("jmpf", 4'hF, 4'h0, 4'hC, 4'h8, 1'b0, 1'b0);
    drive(2'b11, 2'b00, 4'h0, 4'b0000); step();
    check("pcwrap0", {4'h0, pc}, 8'h00);
    step(); check("pcwrap1", {4'h0, pc}, 8'h01);
    for (int i = 0; i < 14; i++) step();
    check("pcwrap16", {4'h0, pc}, 8'h0F);

    // Jump at pc=F: load wins over wrap
    drive(2'b11, 2'b01, 4'h3, 4'b1000); step();
    check_all("jmpatf", 4'h3, 4'h0, 4'hC, 4'h8, 1'b0, 1'b0);
    // Jump with sum=0 sets zf
    drive(2'b11, 2'b00, 4'h0, 4'b1000); step();
    check_all("jmpzero", 4'h0, 4'h0, 4'hC, 4'h8, 1'b1, 1'b0);
    // Jump + load A together
    drive(2'b11, 2'b01, 4'hA, 4'b1001); step();
    check_all("jmpld", 4'hA, 4'hA, 4'hC, 4'h8, 1'b0, 1'b0);

    // Reach pc=4 with zf=1: jump to 3, then a zero-sum plain step
    drive(2'b11, 2'b01, 4'h3, 4'b1000); step();
    drive(2'b11, 2'b00, 4'h0, 4'b0000); step();
    check_all("pre_halt", 4'h4, 4'hA, 4'hC, 4'h8, 1'b1, 1'b0);

    // Halt overrides strobes; nothing updates
    hlt = 1'b1;
    drive(2'b11, 2'b01, 4'h9, 4'b1111); step();
    check_all("halt", 4'h4, 4'hA, 4'hC, 4'h8, 1'b1, 1'b1);
    hlt = 1'b0;
    step();
    en = 1'b0; step();
    en = 1'b1; drive(2'b10, 2'b01, 4'h2, 4'b1111); step(); step();
    check_all("halted_frozen", 4'h4, 4'hA, 4'hC, 4'h8, 1'b1, 1'b1);

    // Reset from HALT; reset has priority over en and strobes
    rst = 1'b1; step();
    check_all("rst_halt", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // en gating: 5 cycles of en=0 with strobes and hlt -> nothing changes
    en = 1'b0; hlt = 1'b1;
    drive(2'b11, 2'b01, 4'h7, 4'b0001);
    for (int i = 0; i < 5; i++) step();
    check_all("en_low", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    hlt = 1'b0; en = 1'b1; step();
    en = 1'b0;
    check_all("en_pulse", 4'h1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    check("en_hold.pc", {4'h0, pc}, 8'h01);

    // Reset mid-program
    en = 1'b1; rst = 1'b1; step(); rst = 1'b0;
    check_all("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
